seq_shifter: RTL and testbench
==============================

Name: seq_shifter

Overview:
- Parametrised, multi-cycle successor to the combinational 1-bit right shifter.
- Shifts an N-bit operand by a run-time amount, one bit position per clock.
- Supports four modes: logical right, logical left, arithmetic right and rotate right.
- Uses a start/busy/done handshake, so it can sit behind a simple controller or ALU sequencer in the lab datapath.

Parameters:
- N, 4, operand width in bits; legal range N >= 2.
- SW, $clog2(N), width of the shift-amount port; derived, not overridden.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous reset, active-low.
- start  input  1  request; sampled only in IDLE.
- mode  input  2  00 SRL, 01 SLL, 10 SRA, 11 ROR; latched on accept.
- shamt  input  SW  shift amount; latched on accept.
- data_in  input  N  operand; latched on accept.
- data_out  output  N  result register.
- busy  output  1  high whenever state != IDLE.
- done  output  1  one-cycle pulse; result valid.

Behaviour:
- Reset (asynchronous, rst_n=0, any state, including mid-shift):
  - state=IDLE, data_out=0, busy=0, done=0, internal counter=0.
  - Operation in progress is abandoned, with no done pulse.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - On start=1 at edge k: load data_out<=data_in, cnt<=shamt, and latch mode.
  - If shamt==0 go to DONE; otherwise go to SHIFT.
  - start=0: hold; data_out keeps its last result.
- SHIFT: each edge performs exactly one 1-bit step on data_out and cnt<=cnt-1; when cnt==1 at the edge, go to DONE.
  - SRL: {1'b0, data_out[N-1:1]}.
  - SLL: {data_out[N-2:0], 1'b0}.
  - SRA: {data_out[N-1], data_out[N-1:1]}.
  - ROR: {data_out[0], data_out[N-1:1]}.
- DONE: done=1 for exactly one cycle, then IDLE unconditionally.
- Latency: done is high in the cycle after edge k+shamt, i.e. shamt+1 cycles after the accept edge. busy is high for shamt+1 cycles.
- data_out:
  - Intermediate values are visible during SHIFT; valid only when done=1.
  - Held unchanged in IDLE until the next accepted start.
- start while busy (SHIFT or DONE): ignored; it is not queued. mode/shamt/data_in changes while busy have no effect.
- Back-to-back operation: start held high continuously is accepted again in the first IDLE cycle after DONE, so the minimum issue interval is shamt+2 cycles.
- shamt >= N (possible when N is not a power of 2):
  - SRL/SLL result 0.
  - SRA result all copies of the sign bit.
  - ROR rotates by shamt mod N. These follow naturally from per-bit iteration; no special-casing.

Optional Feature:
- Macro SEQ_SHIFTER_CARRY_EN.
- When defined: adds output carry_out (1 bit), reset 0.
  - On each SHIFT step, carry_out takes the bit shifted or rotated out: data_out[0] for SRL/SRA/ROR, data_out[N-1] for SLL.
  - On accept, carry_out is cleared to 0, so shamt==0 yields carry_out=0.
  - Held with data_out until the next accept.
- When undefined: no carry_out port and no associated logic; all other behaviour is identical.

Test Plan:
- N=4, SRL, data_in=4'b1011, shamt=2 -> data_out=4'b0010, done one cycle at accept+3, busy high 3 cycles; carry_out=1 if enabled.
- N=4, SRA 4'b1011 shamt=3 -> 4'b1111; SRA 4'b0110 shamt=1 -> 4'b0011; SLL 4'b1011 shamt=1 -> 4'b0110 (carry 1); ROR 4'b1011 shamt=1 -> 4'b1101 (carry 1).
- N=4, shamt=0, data_in=4'b1001, any mode -> done at accept+1, data_out=4'b1001, busy 1 cycle, carry_out=0.
- N=4, SRL 4'b1111 shamt=3:
  - Pulse start with data_in=4'b0000 at accept+1 -> ignored, final result 4'b0001.
  - Then rst_n=0 mid-shift in a second run -> data_out=0, busy=0, done never asserts, next start works normally.
- N=5, SRL 5'b11111 shamt=7 -> 5'b00000; ROR 5'b00001 shamt=7 -> 5'b01000; SRA 5'b10000 shamt=6 -> 5'b11111.
- N=4, start held high for 12 cycles, shamt=1, ROR 4'b0001 -> done pulses every 3 cycles; data_out sequence 4'b1000, 4'b1000... (reloaded each accept).

Source files
------------

// File: rtl/seq_shifter.sv
// Multi-cycle N-bit shifter (SRL/SLL/SRA/ROR), one bit position per clock, start/busy/done handshake.
// Optional carry_out output enabled by defining SEQ_SHIFTER_CARRY_EN.
module seq_shifter #(
    parameter int N  = 4,
    parameter int SW = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [1:0]    mode,
    input  logic [SW-1:0] shamt,
    input  logic [N-1:0]  data_in,
    output logic [N-1:0]  data_out,
    output logic          busy,
    output logic          done
`ifdef SEQ_SHIFTER_CARRY_EN
    ,
    output logic          carry_out
`endif
);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_e;

    localparam logic [1:0] M_SRL = 2'b00;
    localparam logic [1:0] M_SLL = 2'b01;
    localparam logic [1:0] M_SRA = 2'b10;

    state_e        state_q, state_d;
    logic [N-1:0]  data_q, data_d;
    logic [SW-1:0] cnt_q, cnt_d;
    logic [1:0]    mode_q, mode_d;
    logic [N-1:0]  step;

    // One 1-bit step of the latched operation.
    always_comb begin
        case (mode_q)
            M_SRL:   step = {1'b0, data_q[N-1:1]};
            M_SLL:   step = {data_q[N-2:0], 1'b0};
            M_SRA:   step = {data_q[N-1], data_q[N-1:1]};
            default: step = {data_q[0], data_q[N-1:1]};
        endcase
    end

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    data_d  = data_in;
                    cnt_d   = shamt;
                    mode_d  = mode;
                    state_d = (shamt == '0) ? DONE : SHIFT;
                end
            end
            SHIFT: begin
                data_d = step;
                cnt_d  = cnt_q - SW'(1);
                if (cnt_q == SW'(1)) state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            data_q  <= '0;
            cnt_q   <= '0;
            mode_q  <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
        end
    end

`ifdef SEQ_SHIFTER_CARRY_EN
    logic carry_q, carry_d;

    // Bit leaving the register on this step; cleared on accept.
    always_comb begin
        carry_d = carry_q;
        if (state_q == IDLE && start) begin
            carry_d = 1'b0;
        end else if (state_q == SHIFT) begin
            carry_d = (mode_q == M_SLL) ? data_q[N-1] : data_q[0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) carry_q <= 1'b0;
        else        carry_q <= carry_d;
    end

    assign carry_out = carry_q;
`endif

    assign data_out = data_q;
    assign busy     = (state_q != IDLE);
    assign done     = (state_q == DONE);

endmodule

// File: tb/tb_seq_shifter.sv
// Self-checking bench for seq_shifter: N=4 instance checked every cycle against a
// cycle-count/arithmetic model, plus directed literal cases on N=4 and N=5 instances.
module tb_seq_shifter;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic       start4 = 1'b0;
    logic [1:0] mode4  = '0;
    logic [1:0] sh4    = '0;
    logic [3:0] din4   = '0;
    logic [3:0] dout4;
    logic       busy4, done4;

    logic       start5 = 1'b0;
    logic [1:0] mode5  = '0;
    logic [2:0] sh5    = '0;
    logic [4:0] din5   = '0;
    logic [4:0] dout5;
    logic       busy5, done5;

`ifdef SEQ_SHIFTER_CARRY_EN
    logic c4, c5;
`endif

    seq_shifter #(.N(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .mode(mode4), .shamt(sh4),
        .data_in(din4), .data_out(dout4), .busy(busy4), .done(done4)
`ifdef SEQ_SHIFTER_CARRY_EN
        , .carry_out(c4)
`endif
    );

    seq_shifter #(.N(5)) dut5 (
        .clk(clk), .rst_n(rst_n), .start(start5), .mode(mode5), .shamt(sh5),
        .data_in(din5), .data_out(dout5), .busy(busy5), .done(done5)
`ifdef SEQ_SHIFTER_CARRY_EN
        , .carry_out(c5)
`endif
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Result of the whole operation computed directly, not step by step.
    function automatic int ref_res(input int n, input int m, input int d, input int s);
        int mask, sign, k;
        mask = (1 << n) - 1;
        case (m)
            0: return (s >= n) ? 0 : (d >> s);
            1: return (s >= n) ? 0 : ((d << s) & mask);
            2: begin
                sign = (d >> (n - 1)) & 1;
                if (s >= n) return sign ? mask : 0;
                return (d >> s) | (sign ? (mask & ~(mask >> s)) : 0);
            end
            default: begin
                k = s % n;
                return ((d >> k) | (d << (n - k))) & mask;
            end
        endcase
    endfunction

    function automatic int ref_carry(input int n, input int m, input int d, input int s);
        if (s == 0) return 0;
        case (m)
            0: return (s > n) ? 0 : ((d >> (s - 1)) & 1);
            1: return (s > n) ? 0 : ((d >> (n - s)) & 1);
            2: return (d >> (((s - 1) < (n - 1)) ? (s - 1) : (n - 1))) & 1;
            default: return (d >> ((s - 1) % n)) & 1;
        endcase
    endfunction

    // Model: m_left = cycles of busy remaining including this one (0 = idle).
    int m_left = 0;
    int m_res  = 0;
    int m_c    = 0;

    always @(negedge clk) begin
        if (!rst_n) begin
            m_left = 0;
            m_res  = 0;
            m_c    = 0;
        end
        check("busy4", busy4, (m_left > 0) ? 1 : 0);
        check("done4", done4, (m_left == 1) ? 1 : 0);
        if (m_left <= 1) begin
            check("dout4", dout4, m_res);
`ifdef SEQ_SHIFTER_CARRY_EN
            check("carry4", c4, m_c);
`endif
        end
        if (rst_n) begin
            if (m_left > 0) begin
                m_left = m_left - 1;
            end else if (start4) begin
                m_left = sh4 + 1;
                m_res  = ref_res(4, mode4, din4, sh4);
                m_c    = ref_carry(4, mode4, din4, sh4);
            end
        end
    end

    task automatic go4(input logic [1:0] m, input logic [3:0] d, input logic [1:0] s,
                       input int exp, input int expc);
        int n, nb;
        bit got;
        @(posedge clk); #1;
        start4 = 1'b1; mode4 = m; din4 = d; sh4 = s;
        @(posedge clk); #1;
        start4 = 1'b0; mode4 = 2'($urandom); din4 = 4'($urandom); sh4 = 2'($urandom);
        n = 0; nb = 0; got = 0;
        repeat (10) begin
            @(negedge clk);
            n++;
            if (busy4) nb++;
            if (done4 && !got) begin
                got = 1;
                check("lat4", n, s + 1);
                check("res4", dout4, exp);
`ifdef SEQ_SHIFTER_CARRY_EN
                check("cout4", c4, expc);
`endif
            end
        end
        if (!got) check("timeout4", 0, 1);
        check("busycyc4", nb, s + 1);
        if (expc > 1) check("expc_range", expc, 1);
    endtask

    task automatic go5(input logic [1:0] m, input logic [4:0] d, input logic [2:0] s,
                       input int exp, input int expc);
        int n;
        bit got;
        @(posedge clk); #1;
        start5 = 1'b1; mode5 = m; din5 = d; sh5 = s;
        @(posedge clk); #1;
        start5 = 1'b0; din5 = 5'($urandom);
        n = 0; got = 0;
        repeat (12) begin
            @(negedge clk);
            n++;
            if (done5 && !got) begin
                got = 1;
                check("lat5", n, s + 1);
                check("res5", dout5, exp);
                check("model5", dout5, ref_res(5, m, d, s));
`ifdef SEQ_SHIFTER_CARRY_EN
                check("cout5", c5, expc);
`endif
            end
        end
        if (!got) check("timeout5", 0, 1);
        if (expc > 1) check("expc_range", expc, 1);
    endtask

    initial begin
        int dones;
        repeat (2) @(negedge clk);
        check("rst_dout", dout4, 0);
        check("rst_busy", busy4, 0);
        check("rst_done", done4, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        go4(2'b00, 4'b1011, 2'd2, 4'b0010, 1);
        go4(2'b10, 4'b1011, 2'd3, 4'b1111, 0);
        go4(2'b10, 4'b0110, 2'd1, 4'b0011, 0);
        go4(2'b01, 4'b1011, 2'd1, 4'b0110, 1);
        go4(2'b11, 4'b1011, 2'd1, 4'b1101, 1);
        for (int m = 0; m < 4; m++) go4(2'(m), 4'b1001, 2'd0, 4'b1001, 0);

        // Start pulsed while shifting must be ignored.
        @(posedge clk); #1;
        start4 = 1'b1; mode4 = 2'b00; din4 = 4'b1111; sh4 = 2'd3;
        @(posedge clk); #1;
        din4 = 4'b0000; sh4 = 2'd0;
        @(posedge clk); #1;
        start4 = 1'b0;
        repeat (6) @(negedge clk);
        check("ignored_start", dout4, 4'b0001);

        // Reset mid-shift abandons the operation.
        @(posedge clk); #1;
        start4 = 1'b1; mode4 = 2'b00; din4 = 4'b1111; sh4 = 2'd3;
        @(posedge clk); #1;
        start4 = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst_dout", dout4, 0);
        check("midrst_busy", busy4, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        dones = 0;
        repeat (6) begin
            @(negedge clk);
            if (done4) dones++;
        end
        check("midrst_nodone", dones, 0);
        go4(2'b00, 4'b1011, 2'd2, 4'b0010, 1);

        go5(2'b00, 5'b11111, 3'd7, 5'b00000, 0);
        go5(2'b11, 5'b00001, 3'd7, 5'b01000, 0);
        go5(2'b10, 5'b10000, 3'd6, 5'b11111, 1);

        // Start held high: one result every shamt+2 cycles.
        @(posedge clk); #1;
        start4 = 1'b1; mode4 = 2'b11; din4 = 4'b0001; sh4 = 2'd1;
        dones = 0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (done4) begin
                dones++;
                check("b2b_res", dout4, 4'b1000);
            end
            @(posedge clk); #1;
            if (i == 11) start4 = 1'b0;
        end
        check("b2b_dones", dones, 4);

        // Random traffic; inputs keep changing while busy.
        repeat (1500) begin
            @(posedge clk); #1;
            start4 = ($urandom_range(2) == 0);
            mode4  = 2'($urandom);
            din4   = 4'($urandom);
            sh4    = 2'($urandom);
        end
        @(posedge clk); #1;
        start4 = 1'b0;
        repeat (8) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
